instr_fetch_mem: RTL

//   Parametrised, writable instruction memory with a PC-driven fetch engine. Serves

---
 rtl/instr_fetch_mem_if.sv | 26 ++
 rtl/instr_fetch_mem.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem_if.sv
// rtl/instr_fetch_mem_if.sv - fetch/redirect/stream/load bus of the instruction fetch memory
interface instr_fetch_mem_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_fault;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output fetch_en, redirect_valid, redirect_pc, instr_ready, wr_en, wr_addr, wr_data,
    input  instr_valid, instr, instr_pc, instr_fault
  );

  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, instr_ready, wr_en, wr_addr, wr_data,
    output instr_valid, instr, instr_pc, instr_fault
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - writable instruction memory with PC-driven fetch engine and output FIFO
module instr_fetch_mem #(
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 32,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic              clock,
  input logic              reset_n,
  instr_fetch_mem_if.slave bus
);
  localparam int              IDX_W     = $clog2(DEPTH);
  localparam int              PTR_W     = $clog2(BUF_DEPTH);
  localparam int              CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [31:0]     NOP       = 32'h0000_0013;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  // Program storage; survives reset, starts out filled with NOPs.
  logic [31:0]       r_mem [DEPTH] = '{default: NOP};
  logic [31:0]       r_rd_data;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inf_pc;
  logic              r_inf_fault;

  logic [31:0]       r_buf_instr [BUF_DEPTH];
  logic [ADDR_W-1:0] r_buf_pc    [BUF_DEPTH];
  logic              r_buf_fault [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_valid;
  logic              w_pop;
  logic [CNT_W:0]    w_occ;
  logic              w_issue;
  logic              w_pc_fault;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_ok;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.instr_ready;
  // Slots already promised (stored + in flight) after this cycle's pop; an issue needs a free one.
  assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue    = bus.fetch_en & (r_state == ST_RUN) & ~bus.redirect_valid
                    & (w_occ < (CNT_W+1)'(BUF_DEPTH));
  assign w_pc_fault = (r_fetch_pc[1:0] != 2'b00) | ({1'b0, r_fetch_pc} >= MEM_BYTES);
  assign w_rd_idx   = r_fetch_pc[IDX_W+1:2];
  assign w_wr_idx   = bus.wr_addr[IDX_W+1:2];
  // MEM_BYTES is word aligned, so ignoring wr_addr[1:0] does not change the range result.
  assign w_wr_ok    = bus.wr_en & ({1'b0, bus.wr_addr} < MEM_BYTES);

  // Halt state register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Halt on issuing a faulting PC; only a redirect restarts the engine.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid)        w_state_nxt = ST_RUN;
    else if (w_issue && w_pc_fault) w_state_nxt = ST_HALT;
  end

  // Memory write port and synchronous read; a same-edge write leaves the read with old data.
  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[w_wr_idx] <= bus.wr_data;
    if (w_issue && !w_pc_fault) r_rd_data <= r_mem[w_rd_idx];
  end

  // Fetch PC and the single in-flight read tag; redirect discards the in-flight read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_pc  <= RESET_PC;
      r_inflight  <= 1'b0;
      r_inf_pc    <= '0;
      r_inf_fault <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc  <= bus.redirect_pc;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc  <= r_fetch_pc + ADDR_W'(4);
        r_inf_pc    <= r_fetch_pc;
        r_inf_fault <= w_pc_fault;
      end
    end
  end

  // FIFO pointers and occupancy; reset and redirect both empty it.
  always_ff @(posedge clock) begin
    if (!reset_n || bus.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_inflight) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)      r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; a landing read always has a slot thanks to the issue credit check.
  always_ff @(posedge clock) begin
    if (r_inflight) begin
      r_buf_instr[r_wptr] <= r_inf_fault ? NOP : r_rd_data;
      r_buf_pc[r_wptr]    <= r_inf_pc;
      r_buf_fault[r_wptr] <= r_inf_fault;
    end
  end

  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? r_buf_instr[r_rptr] : 32'h0;
  assign bus.instr_pc    = w_valid ? r_buf_pc[r_rptr]    : '0;
  assign bus.instr_fault = w_valid ? r_buf_fault[r_rptr] : 1'b0;
endmodule
